// File: rtl/crypto_sched_pkg.sv
// Shared types and helpers for the crypto job scheduler.
// Optional abort-on-silence behaviour is enabled by CRYPTO_SCHED_TIMEOUT_EN (see crypto_job_sched).
package crypto_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    localparam int CH_W = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/crypto_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the channel that wins a tie.
module crypto_rr_arb2 (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       adv_ch,
    output logic [1:0] gnt
);

    logic ptr;

    // After serving adv_ch, the other channel gets priority.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~adv_ch;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/crypto_job_sched.sv
// Shares one cipher core between two job queues: arbitrate, stream a job in, count its results.
// Define CRYPTO_SCHED_TIMEOUT_EN to abort a job whose results stop arriving for TMO_CYC cycles.
//
// Handshake: a word moves into the core in any cycle where core_in_valid and core_ready are both
// high; core_in_valid is only raised when the queue head is present and the core is ready, and
// the same cycle pops the queue via chN_rd_en. Result words are single-cycle core_out_valid
// strobes with no back-pressure.
module crypto_job_sched
    import crypto_sched_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BLK_WORDS = 8,
    parameter int RES_WORDS = 8,
    parameter int TMO_CYC   = 4096
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          ch0_blk_rdy,
    input  logic          ch0_empty,
    input  logic [DW-1:0] ch0_data,
    output logic          ch0_rd_en,
    input  logic          ch1_blk_rdy,
    input  logic          ch1_empty,
    input  logic [DW-1:0] ch1_data,
    output logic          ch1_rd_en,
    input  logic          core_ready,
    output logic          core_in_valid,
    output logic [DW-1:0] core_data,
    input  logic          core_out_valid,
    output logic          res_valid,
    output logic          res_ch,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          job_done,
    output logic          err_stray,
    output logic          err_tmo,
    output logic [1:0]    state_dbg
);

    localparam int WCW = cnt_w(BLK_WORDS);
    localparam int RCW = cnt_w(RES_WORDS);

    sched_state_t   state;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] res_cnt;
    logic [1:0]     arb_gnt;
    logic           arb_adv;
    logic           in_job;
    logic           feed;
    logic           xfer;
    logic           sel_empty;
    logic [DW-1:0]  sel_data;
    logic           last_word;
    logic           last_res;
    logic           tmo_fire;

    crypto_rr_arb2 u_arb (
        .hclk    (hclk),
        .hresetn (hresetn),
        .req     ({ch1_blk_rdy, ch0_blk_rdy}),
        .adv     (arb_adv),
        .adv_ch  (res_ch),
        .gnt     (arb_gnt)
    );

    // res_ch doubles as the data-path select: it is loaded together with grant.
    assign sel_empty = res_ch ? ch1_empty : ch0_empty;
    assign sel_data  = res_ch ? ch1_data  : ch0_data;

    assign feed      = (state == ST_FEED);
    assign in_job    = (state == ST_FEED) || (state == ST_WAIT);
    assign xfer      = feed && core_ready && !sel_empty;

    assign core_in_valid = xfer;
    assign ch0_rd_en     = xfer && !res_ch;
    assign ch1_rd_en     = xfer &&  res_ch;
    assign core_data     = feed ? sel_data : '0;

    assign res_valid = core_out_valid && in_job;
    assign err_stray = core_out_valid && !in_job && hresetn;

    assign last_word = xfer && (word_cnt == WCW'(BLK_WORDS - 1));
    assign last_res  = res_valid && (res_cnt == RCW'(RES_WORDS - 1));

    assign busy      = (state != ST_IDLE);
    assign job_done  = (state == ST_DONE);
    assign state_dbg = state;
    assign arb_adv   = (state == ST_DONE) || tmo_fire;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
    localparam int TW = cnt_w(TMO_CYC);
    logic [TW-1:0] tmo_cnt;

    // Held at zero outside WAIT, so it starts fresh on every WAIT entry.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            tmo_cnt <= '0;
        end else if ((state != ST_WAIT) || core_out_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_fire = (state == ST_WAIT) && !core_out_valid && (tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            grant    <= 2'b00;
            res_ch   <= 1'b0;
            word_cnt <= '0;
            res_cnt  <= '0;
            err_tmo  <= 1'b0;
        end else begin
            err_tmo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        grant  <= arb_gnt;
                        res_ch <= arb_gnt[1];
                        state  <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + WCW'(1);
                    end
                    if (res_valid) begin
                        res_cnt <= res_cnt + RCW'(1);
                    end
                    if (last_res) begin
                        state <= ST_DONE;
                    end else if (last_word) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (last_res) begin
                        res_cnt <= res_cnt + RCW'(1);
                        state   <= ST_DONE;
                    end else if (tmo_fire) begin
                        grant    <= 2'b00;
                        word_cnt <= '0;
                        res_cnt  <= '0;
                        err_tmo  <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (res_valid) begin
                        res_cnt <= res_cnt + RCW'(1);
                    end
                end
                ST_DONE: begin
                    grant    <= 2'b00;
                    word_cnt <= '0;
                    res_cnt  <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_job_sched.sv
// Directed bench for crypto_job_sched with FIFO/core models and a scoreboard monitor.
module tb_crypto_job_sched;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic hclk;
    logic hresetn;

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // ---------------- DUT ----------------
    logic          ch0_blk_rdy, ch1_blk_rdy;
    logic          ch0_empty, ch1_empty;
    logic [DW-1:0] ch0_data, ch1_data;
    logic          ch0_rd_en, ch1_rd_en;
    logic          core_ready, core_in_valid, core_out_valid;
    logic [DW-1:0] core_data;
    logic          res_valid, res_ch, busy, job_done, err_stray, err_tmo;
    logic [1:0]    grant, state_dbg;

    logic          fifo_empty0, fifo_empty1;
    logic          force_empty0;

    assign ch0_empty = fifo_empty0 | force_empty0;
    assign ch1_empty = fifo_empty1;

    crypto_job_sched #(
        .DW(DW), .BLK_WORDS(8), .RES_WORDS(8), .TMO_CYC(16)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .ch0_blk_rdy(ch0_blk_rdy), .ch0_empty(ch0_empty), .ch0_data(ch0_data), .ch0_rd_en(ch0_rd_en),
        .ch1_blk_rdy(ch1_blk_rdy), .ch1_empty(ch1_empty), .ch1_data(ch1_data), .ch1_rd_en(ch1_rd_en),
        .core_ready(core_ready), .core_in_valid(core_in_valid), .core_data(core_data),
        .core_out_valid(core_out_valid), .res_valid(res_valid), .res_ch(res_ch),
        .grant(grant), .busy(busy), .job_done(job_done),
        .err_stray(err_stray), .err_tmo(err_tmo), .state_dbg(state_dbg)
    );

    // ---------------- queue and core models ----------------
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int  acc_cnt;
    int  pending;
    bit  core_auto;
    bit  pop0, pop1;

    task automatic refresh();
        ch0_data    = (q0.size() > 0) ? q0[0] : '0;
        ch1_data    = (q1.size() > 0) ? q1[0] : '0;
        fifo_empty0 = (q0.size() == 0);
        fifo_empty1 = (q1.size() == 0);
        ch0_blk_rdy = (q0.size() >= 8);
        ch1_blk_rdy = (q1.size() >= 8);
    endtask

    // Capture pops and accepted words mid-cycle; the core answers 8 results per 8 words.
    always @(negedge hclk) begin
        if (!hresetn) begin
            acc_cnt = 0;
            pending = 0;
            pop0    = 1'b0;
            pop1    = 1'b0;
        end else begin
            pop0 = ch0_rd_en;
            pop1 = ch1_rd_en;
            if (core_out_valid && pending > 0) pending = pending - 1;
            if (core_in_valid && core_ready) begin
                acc_cnt = acc_cnt + 1;
                if (acc_cnt == 8) begin
                    acc_cnt = 0;
                    pending = pending + 8;
                end
            end
        end
    end

    always @(posedge hclk) begin
        #1;
        if (pop0 && q0.size() > 0) void'(q0.pop_front());
        if (pop1 && q1.size() > 0) void'(q1.pop_front());
        core_out_valid = core_auto && (pending > 0) && hresetn;
        refresh();
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [0:0]    exp_res_q[$];
    logic [1:0]    exp_job_q[$];
    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: unexpected output event", name);
    endtask

    always @(negedge hclk) begin
        if (hresetn) begin
            if (core_in_valid) begin
                if (exp_q.size() == 0) fail("word_extra");
                else chk("core_word", core_data, exp_q.pop_front());
            end
            if (res_valid) begin
                if (exp_res_q.size() == 0) fail("res_extra");
                else chk("res_ch", {31'd0, res_ch}, {31'd0, exp_res_q.pop_front()});
            end
            if (job_done) begin
                if (exp_job_q.size() == 0) fail("job_extra");
                else chk("job_grant", {30'd0, grant}, {30'd0, exp_job_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge hclk);
        #2;
    endtask

    task automatic load_job(input bit ch, input logic [DW-1:0] base);
        for (int i = 0; i < 8; i++) begin
            if (ch) q1.push_back(base + DW'(i));
            else    q0.push_back(base + DW'(i));
        end
    endtask

    task automatic expect_job(input bit ch, input logic [DW-1:0] base);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(base + DW'(i));
            exp_res_q.push_back(ch);
        end
        exp_job_q.push_back(ch ? 2'b10 : 2'b01);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy && exp_q.size() == 0 && exp_res_q.size() == 0 && exp_job_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: timeout, words %0d results %0d jobs %0d outstanding",
                      name, exp_q.size(), exp_res_q.size(), exp_job_q.size());
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (state_dbg == st) begin
                ok = 1'b1;
                break;
            end
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: state %0d never reached, last %0d", name, st, state_dbg);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_grant"}, {30'd0, grant}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_in_valid"}, {31'd0, core_in_valid}, 32'd0);
        chk({name, "_rd_en"}, {30'd0, ch1_rd_en, ch0_rd_en}, 32'd0);
        chk({name, "_core_data"}, core_data, 32'd0);
        chk({name, "_flags"}, {27'd0, res_valid, res_ch, job_done, err_stray, err_tmo}, 32'd0);
        chk({name, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        n_pass = 0;
        n_total = 0;
        hresetn = 1'b0;
        core_ready = 1'b0;
        core_auto = 1'b1;
        core_out_valid = 1'b0;
        force_empty0 = 1'b0;
        refresh();
        #12;
        chk_all_zero("reset");
        step();
        hresetn = 1'b1;
        core_ready = 1'b1;

        // Single ch0 job: latency, 8 back-to-back words, tagged results.
        load_job(1'b0, 32'h1);
        expect_job(1'b0, 32'h1);
        for (int i = 0; i < 10 && !ch0_blk_rdy; i++) step();
        @(negedge hclk);
        chk("t1_grant_idle", {30'd0, grant}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge hclk);
            if (i == 0) chk("t1_grant", {30'd0, grant}, 32'd1);
            chk("t1_in_valid", {31'd0, core_in_valid}, 32'd1);
        end
        wait_idle(60, "t1_done");

        // Both channels ready from reset: ch0, ch1, ch0, ch1.
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
        load_job(1'b0, 32'h10); load_job(1'b0, 32'h18);
        load_job(1'b1, 32'h20); load_job(1'b1, 32'h28);
        expect_job(1'b0, 32'h10);
        expect_job(1'b1, 32'h20);
        expect_job(1'b0, 32'h18);
        expect_job(1'b1, 32'h28);
        wait_idle(200, "t2_rr");

        // Stalls mid-FEED: core not ready, then queue empty.
        load_job(1'b0, 32'h31);
        expect_job(1'b0, 32'h31);
        wait_state(2'd1, 20, "t3_feed");
        step(); step(); step();
        core_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk("t3_nr_in_valid", {31'd0, core_in_valid}, 32'd0);
            chk("t3_nr_rd_en", {31'd0, ch0_rd_en}, 32'd0);
        end
        step();
        core_ready = 1'b1;
        force_empty0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge hclk);
            chk("t3_em_in_valid", {31'd0, core_in_valid}, 32'd0);
            chk("t3_em_rd_en", {31'd0, ch0_rd_en}, 32'd0);
        end
        step();
        force_empty0 = 1'b0;
        @(negedge hclk);
        chk("t3_resume_data", core_data, 32'h34);
        wait_idle(60, "t3_done");

        // Stray result while idle.
        pending = 1;
        step();
        @(negedge hclk);
        chk("t4_stray", {31'd0, err_stray}, 32'd1);
        chk("t4_res_valid", {31'd0, res_valid}, 32'd0);
        chk("t4_state", {30'd0, state_dbg}, 32'd0);
        step();
        @(negedge hclk);
        chk("t4_stray_end", {31'd0, err_stray}, 32'd0);

`ifdef CRYPTO_SCHED_TIMEOUT_EN
        // No results after FEED: abort after 16 WAIT cycles, then serve the other channel.
        core_auto = 1'b0;
        load_job(1'b0, 32'h51);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h51 + 32'(i));
        wait_state(2'd2, 30, "t5_wait");
        for (int i = 0; i < 16; i++) begin
            @(negedge hclk);
            if (i == 15) begin
                chk("t5_tmo_early", {31'd0, err_tmo}, 32'd0);
                chk("t5_still_wait", {30'd0, state_dbg}, 32'd2);
            end
        end
        @(negedge hclk);
        chk("t5_tmo", {31'd0, err_tmo}, 32'd1);
        chk("t5_idle", {30'd0, state_dbg}, 32'd0);
        chk("t5_grant", {30'd0, grant}, 32'd0);
        @(negedge hclk);
        chk("t5_tmo_end", {31'd0, err_tmo}, 32'd0);
        step();
        pending = 0;
        core_auto = 1'b1;
        load_job(1'b0, 32'h61);
        load_job(1'b1, 32'h71);
        expect_job(1'b1, 32'h71);
        expect_job(1'b0, 32'h61);
        wait_idle(120, "t5_after");
`endif

        // Reset during the fourth word: outputs drop at once, job restarts from word 0.
        load_job(1'b0, 32'h41);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h41 + 32'(i));
        wait_state(2'd1, 20, "t6_feed");
        step(); step(); step();
        hresetn = 1'b0;
        #1;
        chk_all_zero("t6_async");
        q0.delete();
        load_job(1'b0, 32'h41);
        expect_job(1'b0, 32'h41);
        step(); step();
        hresetn = 1'b1;
        wait_idle(60, "t6_restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
